// File: rtl/pulse_gen_multi_if.sv
// Pulse generator control/status bundle: per-channel launch, abort, timing
// fields and the resulting waveforms and strobes.
interface pulse_gen_multi_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
);
   logic [CHANNELS-1:0]       start;
   logic [CHANNELS-1:0]       stop;
   logic [CHANNELS-1:0]       periodic;
   logic [CHANNELS*CNT_W-1:0] delay;
   logic [CHANNELS*CNT_W-1:0] width;
   logic [CHANNELS-1:0]       signal;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS-1:0]       done;

   modport master (
      output start, stop, periodic, delay, width,
      input  signal, busy, done
   );

   modport slave (
      input  start, stop, periodic, delay, width,
      output signal, busy, done
   );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel cycle-counted pulse generator: each channel emits D low cycles
// then W high cycles, one-shot or periodic, with abort and completion strobe.
module pulse_gen_multi #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   pulse_gen_multi_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2
   } state_t;

   state_t              r_state [CHANNELS];
   logic [CNT_W-1:0]    r_cnt   [CHANNELS];
   logic [CNT_W-1:0]    r_d     [CHANNELS];
   logic [CNT_W-1:0]    r_w     [CHANNELS];
   logic [CHANNELS-1:0] r_per;
   logic [CHANNELS-1:0] r_signal;
   logic [CHANNELS-1:0] r_busy;
   logic [CHANNELS-1:0] r_done;

   // A zero width still produces a one-cycle pulse.
   function automatic logic [CNT_W-1:0] f_wp(input logic [CNT_W-1:0] w);
      return (w == '0) ? CNT_W'(1) : w;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_d[i]     <= '0;
            r_w[i]     <= '0;
         end
         r_per    <= '0;
         r_signal <= '0;
         r_busy   <= '0;
         r_done   <= '0;
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            r_done[i] <= 1'b0;
            if (bus.stop[i]) begin
               r_state[i]  <= ST_IDLE;
               r_cnt[i]    <= '0;
               r_signal[i] <= 1'b0;
               r_busy[i]   <= 1'b0;
            end else begin
               case (r_state[i])
                  ST_IDLE: begin
                     if (bus.start[i]) begin
                        r_d[i]    <= bus.delay[i*CNT_W +: CNT_W];
                        r_w[i]    <= f_wp(bus.width[i*CNT_W +: CNT_W]);
                        r_per[i]  <= bus.periodic[i];
                        r_busy[i] <= 1'b1;
                        if (bus.delay[i*CNT_W +: CNT_W] == '0) begin
                           r_state[i]  <= ST_HIGH;
                           r_cnt[i]    <= f_wp(bus.width[i*CNT_W +: CNT_W]) - CNT_W'(1);
                           r_signal[i] <= 1'b1;
                        end else begin
                           r_state[i]  <= ST_DELAY;
                           r_cnt[i]    <= bus.delay[i*CNT_W +: CNT_W] - CNT_W'(1);
                           r_signal[i] <= 1'b0;
                        end
                     end
                  end
                  ST_DELAY: begin
                     if (r_cnt[i] == '0) begin
                        r_state[i]  <= ST_HIGH;
                        r_cnt[i]    <= r_w[i] - CNT_W'(1);
                        r_signal[i] <= 1'b1;
                     end else begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                     end
                  end
                  ST_HIGH: begin
                     if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                     end else if (r_per[i]) begin
                        // Relaunch from latched values; D==0 keeps the output high.
                        if (r_d[i] == '0) begin
                           r_cnt[i] <= r_w[i] - CNT_W'(1);
                        end else begin
                           r_state[i]  <= ST_DELAY;
                           r_cnt[i]    <= r_d[i] - CNT_W'(1);
                           r_signal[i] <= 1'b0;
                        end
                     end else begin
                        r_state[i]  <= ST_IDLE;
                        r_signal[i] <= 1'b0;
                        r_busy[i]   <= 1'b0;
                        r_done[i]   <= 1'b1;
                     end
                  end
                  default: begin
                     r_state[i]  <= ST_IDLE;
                     r_cnt[i]    <= '0;
                     r_signal[i] <= 1'b0;
                     r_busy[i]   <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.signal = r_signal;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: per-cycle comparison against a
// launch-time arithmetic model plus literal checks at hand-derived edges.
module tb_pulse_gen_multi;
   localparam int unsigned CH = 4;
   localparam int unsigned CW = 8;

   logic clock = 1'b0;
   logic reset;

   pulse_gen_multi_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

   pulse_gen_multi #(.CHANNELS(CH), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a channel is described only by its launch edge and latched D, W', mode.
   bit m_act [CH];
   int m_k   [CH];
   int m_d   [CH];
   int m_w   [CH];
   bit m_per [CH];
   int cyc = 0;

   function automatic void model_out(input int ch, input int c,
                                     output bit s, output bit b, output bit d);
      int e, p;
      s = 1'b0; b = 1'b0; d = 1'b0;
      if (m_act[ch]) begin
         e = c - m_k[ch];
         p = m_d[ch] + m_w[ch];
         if (m_per[ch]) begin
            b = 1'b1;
            s = ((e % p) >= m_d[ch]);
         end else begin
            b = (e < p);
            s = (e >= m_d[ch]) && (e < p);
            d = (e == p);
         end
      end
   endfunction

   always @(posedge clock) begin
      bit pb, ps, pd;
      logic [CH-1:0] es, eb, ed;
      cyc++;
      for (int ch = 0; ch < int'(CH); ch++) begin
         model_out(ch, cyc - 1, ps, pb, pd);
         if (reset || bus.stop[ch]) begin
            m_act[ch] = 1'b0;
         end else if (!pb && bus.start[ch]) begin
            m_act[ch] = 1'b1;
            m_k[ch]   = cyc;
            m_d[ch]   = int'(bus.delay[ch*CW +: CW]);
            m_w[ch]   = int'(bus.width[ch*CW +: CW]);
            if (m_w[ch] == 0) m_w[ch] = 1;
            m_per[ch] = bus.periodic[ch];
         end
      end
      for (int ch = 0; ch < int'(CH); ch++) begin
         model_out(ch, cyc, ps, pb, pd);
         es[ch] = ps; eb[ch] = pb; ed[ch] = pd;
      end
      #1;
      n_checks += 3;
      if (bus.signal !== es) begin
         n_fail++;
         $display("FAIL cyc%0d signal: got %b expected %b", cyc, bus.signal, es);
      end
      if (bus.busy !== eb) begin
         n_fail++;
         $display("FAIL cyc%0d busy: got %b expected %b", cyc, bus.busy, eb);
      end
      if (bus.done !== ed) begin
         n_fail++;
         $display("FAIL cyc%0d done: got %b expected %b", cyc, bus.done, ed);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_ch(input int ch, input int d, input int w, input bit p);
      bus.delay[ch*CW +: CW] = CW'(d);
      bus.width[ch*CW +: CW] = CW'(w);
      bus.periodic[ch]       = p;
   endtask

   // Drive start/stop for exactly one edge; returns just after that edge.
   task automatic pulse_in(input logic [CH-1:0] st, input logic [CH-1:0] sp);
      bus.start = st;
      bus.stop  = sp;
      @(negedge clock);
      bus.start = '0;
      bus.stop  = '0;
   endtask

   initial begin
      for (int ch = 0; ch < int'(CH); ch++) m_act[ch] = 1'b0;
      reset        = 1'b1;
      bus.start    = '1;
      bus.stop     = '0;
      bus.periodic = '0;
      bus.delay    = '0;
      bus.width    = '0;
      wait_n(2);
      chk("rst_signal", 32'(bus.signal), 32'h0);
      chk("rst_busy",   32'(bus.busy),   32'h0);
      chk("rst_done",   32'(bus.done),   32'h0);
      reset     = 1'b0;
      bus.start = '0;
      wait_n(2);

      // One-shot ch0, D=3 W=2
      set_ch(0, 3, 2, 1'b0);
      pulse_in(4'b0001, 4'b0000);
      chk("os_busy_k",   32'(bus.busy[0]),   32'h1);
      chk("os_sig_k",    32'(bus.signal[0]), 32'h0);
      wait_n(3);
      chk("os_sig_k3",   32'(bus.signal[0]), 32'h1);
      wait_n(1);
      chk("os_sig_k4",   32'(bus.signal[0]), 32'h1);
      wait_n(1);
      chk("os_sig_k5",   32'(bus.signal[0]), 32'h0);
      chk("os_done_k5",  32'(bus.done[0]),   32'h1);
      chk("os_busy_k5",  32'(bus.busy[0]),   32'h0);
      wait_n(1);
      chk("os_done_k6",  32'(bus.done[0]),   32'h0);

      // Periodic ch1, D=2 W=3, stop at k+9
      set_ch(1, 2, 3, 1'b1);
      pulse_in(4'b0010, 4'b0000);
      wait_n(2);
      chk("per_sig_k2",  32'(bus.signal[1]), 32'h1);
      wait_n(3);
      chk("per_sig_k5",  32'(bus.signal[1]), 32'h0);
      wait_n(2);
      chk("per_sig_k7",  32'(bus.signal[1]), 32'h1);
      wait_n(1);
      pulse_in(4'b0000, 4'b0010);
      chk("per_stop_sig",  32'(bus.signal[1]), 32'h0);
      chk("per_stop_busy", 32'(bus.busy[1]),   32'h0);
      chk("per_stop_done", 32'(bus.done[1]),   32'h0);
      wait_n(2);

      // Edge values ch2: D=0 W=0, then D=255 W=255
      set_ch(2, 0, 0, 1'b0);
      pulse_in(4'b0100, 4'b0000);
      chk("z_sig_k",     32'(bus.signal[2]), 32'h1);
      wait_n(1);
      chk("z_sig_k1",    32'(bus.signal[2]), 32'h0);
      chk("z_done_k1",   32'(bus.done[2]),   32'h1);
      wait_n(1);
      set_ch(2, 255, 255, 1'b0);
      pulse_in(4'b0100, 4'b0000);
      wait_n(254);
      chk("max_sig_k254", 32'(bus.signal[2]), 32'h0);
      wait_n(1);
      chk("max_sig_k255", 32'(bus.signal[2]), 32'h1);
      wait_n(254);
      chk("max_sig_k509", 32'(bus.signal[2]), 32'h1);
      wait_n(1);
      chk("max_sig_k510", 32'(bus.signal[2]), 32'h0);
      chk("max_done_k510", 32'(bus.done[2]),  32'h1);
      wait_n(2);

      // Retrigger ignored on ch3, then start+stop together in IDLE
      set_ch(3, 5, 2, 1'b0);
      pulse_in(4'b1000, 4'b0000);
      wait_n(1);
      set_ch(3, 1, 7, 1'b1);
      pulse_in(4'b1000, 4'b0000);
      wait_n(3);
      chk("rt_sig_k5",   32'(bus.signal[3]), 32'h1);
      wait_n(2);
      chk("rt_sig_k7",   32'(bus.signal[3]), 32'h0);
      chk("rt_done_k7",  32'(bus.done[3]),   32'h1);
      wait_n(1);
      pulse_in(4'b1000, 4'b1000);
      chk("ss_busy",     32'(bus.busy[3]),   32'h0);
      wait_n(2);

      // Independence: all channels together, ch0 aborted at k+1
      set_ch(0, 1, 2, 1'b0);
      set_ch(1, 3, 1, 1'b0);
      set_ch(2, 0, 4, 1'b0);
      set_ch(3, 2, 2, 1'b0);
      pulse_in(4'b1111, 4'b0000);
      chk("ind_sig_k",   32'(bus.signal), 32'h4);
      pulse_in(4'b0000, 4'b0001);
      chk("ind_busy_k1", 32'(bus.busy),   32'he);
      chk("ind_sig_k1",  32'(bus.signal), 32'h4);
      wait_n(3);
      chk("ind_done_k4", 32'(bus.done),   32'he);
      wait_n(2);

      // Periodic D=0 stays high until reset clears it
      set_ch(0, 0, 0, 1'b1);
      pulse_in(4'b0001, 4'b0000);
      wait_n(5);
      chk("cont_sig",    32'(bus.signal[0]), 32'h1);
      reset = 1'b1;
      wait_n(1);
      reset = 1'b0;
      chk("mrst_sig",    32'(bus.signal), 32'h0);
      chk("mrst_busy",   32'(bus.busy),   32'h0);
      chk("mrst_done",   32'(bus.done),   32'h0);
      wait_n(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Parametrised, fully synchronous multi-channel pulse generator that replaces delay-based behavioural pulse modules with cycle-counted, synthesizable timing. Each channel independently produces a programmable low-delay followed by a programmable high-width on its output, in one-shot or periodic mode, with abort and completion strobes. It sits beside the shared clock generator and feeds stimulus and timing waveforms to downstream blocks and benches.

## Interface

Parameters:
- CHANNELS, 4, number of independent pulse channels
- CNT_W, 8, width of each delay/width field; max programmable count 2^CNT_W-1

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; all channels to IDLE
- start  in  CHANNELS  per-channel launch request, sampled each rising edge
- stop  in  CHANNELS  per-channel abort, sampled each rising edge
- periodic  in  CHANNELS  mode select, latched on launch: 1 = repeat, 0 = one-shot
- delay  in  CHANNELS*CNT_W  channel i at bits [i*CNT_W +: CNT_W]; low cycles before rise (D)
- width  in  CHANNELS*CNT_W  channel i at bits [i*CNT_W +: CNT_W]; high cycles (W)
- signal  out  CHANNELS  registered pulse output
- busy  out  CHANNELS  1 while channel is not IDLE
- done  out  CHANNELS  one-cycle strobe when a one-shot pulse completes normally

## Operation

- One FSM per channel, states IDLE, DELAY, HIGH; one CNT_W-bit down-counter plus latched D, W, mode per channel.
- signal = (state == HIGH), busy = (state != IDLE), both registered; done is a registered strobe.
- IDLE: on start=1 and stop=0, latch D, W, periodic. If D==0 go to HIGH, cnt <= W'-1; else go to DELAY, cnt <= D-1.
- W' = W, except W==0 is treated as W'=1 (no zero-width pulses).
- DELAY: cnt==0 -> HIGH, cnt <= W'-1; else cnt decrements.
- HIGH: cnt!=0 -> decrement. cnt==0 -> if latched periodic: relaunch with latched D/W' (DELAY if D>0, else stay HIGH with cnt <= W'-1); else go to IDLE and assert done for one cycle.
- stop=1 in any state takes priority: next state IDLE, signal and busy drop at that edge, done not asserted.
- start while busy is ignored (no retrigger, no re-latch). delay/width/periodic changes mid-pulse have no effect until the next launch.
- start and stop asserted together in IDLE: stop wins, channel stays IDLE.
- Periodic with D==0: signal stays continuously high until stop.
- Channels are fully independent; no shared arbitration.
- Counters never wrap; maximum D and W are 2^CNT_W-1 cycles.

## Timing

- Reset: all states IDLE, counters 0, signal=0, busy=0, done=0 after the first edge with reset=1; reset overrides start/stop.
- Launch sampled at edge k: busy=1 from edge k. signal rises at edge k+D, falls at edge k+D+W'.
- One-shot: done=1 for exactly the cycle after edge k+D+W'; busy falls at that same edge. New start accepted at edge k+D+W'+1 at earliest.
- Periodic: period D+W' cycles; rises at k+D+n(D+W'), n >= 0.
- stop sampled at edge s: signal=0, busy=0 from edge s.
- Reset mid-pulse: same as stop, applied to all channels; no done.

## Test plan

- Reset: hold reset 2 cycles with start=all ones -> signal, busy, done all 0; no launch occurs.
- One-shot ch0, D=3, W=2, start at edge 10 -> busy high from edge 10, signal high edges 13-14, low from edge 15, done high exactly cycle after edge 15 only.
- Periodic ch1, D=2, W=3 -> signal rises at edges k+2, k+7, k+12; stop at edge k+9 -> signal/busy 0 from edge k+9, done never asserts.
- Edge values ch2: D=0, W=0 -> signal high one cycle starting at launch edge, done follows; D=255, W=255 (CNT_W=8) -> rise at k+255, fall at k+510.
- Retrigger/priority ch3: start again while in DELAY with different D -> original timing unchanged; start+stop same cycle in IDLE -> stays IDLE.
- Independence: launch all 4 channels at same edge with distinct D/W -> each output matches its own formula; stop on ch0 leaves ch1-ch3 unaffected.
